// File: rtl/skipper_cds_accum_if.sv
// Pixel output handshake between the CDS accumulator and the readout framer.
// The master presents a signed pixel and holds it until the slave takes it.
interface skipper_cds_accum_if #(
  parameter int ACC_WIDTH = 36
) ();
  logic signed [ACC_WIDTH-1:0] pixel_data;
  logic                        pixel_valid;
  logic                        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/skipper_cds_accum.sv
// CDS + skipper averaging: sums (signal - baseline) over skip iterations.
// Define CDS_SATURATE_EN to clip the accumulator instead of wrapping.
module skipper_cds_accum #(
  parameter int ADC_WIDTH  = 16,
  parameter int SKIP_WIDTH = 10,
  parameter int WIN_WIDTH  = 8,
  parameter int ACC_WIDTH  = ADC_WIDTH + WIN_WIDTH + SKIP_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SKIP_WIDTH-1:0] skip_samples,
  input  logic                  phi1,
  input  logic                  phi2,
  input  logic [ADC_WIDTH-1:0]  adc_data,
  input  logic                  adc_valid,
  skipper_cds_accum_if.master   pix,
  output logic [3:0]            err_flags,
  output logic                  pixel_sat
);
  localparam int SUM_W = ADC_WIDTH + WIN_WIDTH;
  localparam int DIF_W = SUM_W + 1;

  typedef enum logic [2:0] {
    IDLE, BASE, SIG, UPDATE, OUTPUT
  } state_t;

  state_t                  state_q, state_d;
  logic                    phi1_q, phi2_q;
  logic [SKIP_WIDTH-1:0]   skip_q, skip_d;
  logic [SKIP_WIDTH-1:0]   iter_q, iter_d;
  logic [SUM_W-1:0]        base_sum_q, base_sum_d;
  logic [SUM_W-1:0]        sig_sum_q, sig_sum_d;
  logic [WIN_WIDTH-1:0]    base_cnt_q, base_cnt_d;
  logic [WIN_WIDTH-1:0]    sig_cnt_q, sig_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]              err_q, err_d;
  logic                    sat_q, sat_d;
  logic                    overlap, take;
  logic signed [DIF_W-1:0] diff;

  assign overlap = phi1 & phi2;
  assign take    = adc_valid & ~overlap;
  assign diff    = $signed({1'b0, sig_sum_q})
                 - $signed({1'b0, base_sum_q});

`ifdef CDS_SATURATE_EN
  localparam int EXT_W =
    (ACC_WIDTH > DIF_W ? ACC_WIDTH : DIF_W) + 1;
  logic signed [EXT_W-1:0] sum_ext, max_ext, min_ext;
  assign max_ext = EXT_W'($signed({1'b0, {(ACC_WIDTH-1){1'b1}}}));
  assign min_ext = EXT_W'($signed({1'b1, {(ACC_WIDTH-1){1'b0}}}));
  assign sum_ext = EXT_W'(acc_q) + EXT_W'(diff);
`endif

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    iter_d     = iter_q;
    base_sum_d = base_sum_q;
    sig_sum_d  = sig_sum_q;
    base_cnt_d = base_cnt_q;
    sig_cnt_d  = sig_cnt_q;
    acc_d      = acc_q;
    err_d      = err_q;
    sat_d      = sat_q;
    if (state_q != IDLE) begin
      if (start)   err_d[2] = 1'b1;
      if (overlap) err_d[1] = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          skip_d     = skip_samples;
          iter_d     = '0;
          acc_d      = '0;
          err_d      = '0;
          sat_d      = 1'b0;
          base_sum_d = '0;
          sig_sum_d  = '0;
          base_cnt_d = '0;
          sig_cnt_d  = '0;
          state_d    = BASE;
        end
      end
      BASE: begin
        if (phi1 && take) begin
          if (&base_cnt_q) begin
            err_d[3] = 1'b1;
          end else begin
            base_cnt_d = base_cnt_q + 1'b1;
            base_sum_d = base_sum_q + SUM_W'(adc_data);
          end
        end
        if (phi1_q && !phi1) state_d = SIG;
      end
      SIG: begin
        if (phi2 && take) begin
          if (&sig_cnt_q) begin
            err_d[3] = 1'b1;
          end else begin
            sig_cnt_d = sig_cnt_q + 1'b1;
            sig_sum_d = sig_sum_q + SUM_W'(adc_data);
          end
        end
        if (phi2_q && !phi2) state_d = UPDATE;
      end
      UPDATE: begin
        if (base_cnt_q != sig_cnt_q) err_d[0] = 1'b1;
`ifdef CDS_SATURATE_EN
        if (sum_ext > max_ext) begin
          acc_d = max_ext[ACC_WIDTH-1:0];
          sat_d = 1'b1;
        end else if (sum_ext < min_ext) begin
          acc_d = min_ext[ACC_WIDTH-1:0];
          sat_d = 1'b1;
        end else begin
          acc_d = sum_ext[ACC_WIDTH-1:0];
        end
`else
        acc_d = acc_q + ACC_WIDTH'(diff);
`endif
        base_sum_d = '0;
        sig_sum_d  = '0;
        base_cnt_d = '0;
        sig_cnt_d  = '0;
        if (iter_q == skip_q) begin
          state_d = OUTPUT;
        end else begin
          iter_d  = iter_q + 1'b1;
          state_d = BASE;
        end
      end
      OUTPUT: begin
        if (pix.pixel_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
      skip_q     <= '0;
      iter_q     <= '0;
      base_sum_q <= '0;
      sig_sum_q  <= '0;
      base_cnt_q <= '0;
      sig_cnt_q  <= '0;
      acc_q      <= '0;
      err_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phi1_q     <= phi1;
      phi2_q     <= phi2;
      skip_q     <= skip_d;
      iter_q     <= iter_d;
      base_sum_q <= base_sum_d;
      sig_sum_q  <= sig_sum_d;
      base_cnt_q <= base_cnt_d;
      sig_cnt_q  <= sig_cnt_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
    end
  end

  assign pix.pixel_data  = acc_q;
  assign pix.pixel_valid = (state_q == OUTPUT);
  assign err_flags       = err_q;
  assign pixel_sat       = sat_q;
endmodule

// File: tb/tb_skipper_cds_accum.sv
// Randomized bench for skipper_cds_accum: a 36-bit and a 12-bit
// accumulator instance run in lockstep against a list-of-diffs model.
module tb_skipper_cds_accum;
  localparam int AW   = 16;
  localparam int SW   = 10;
  localparam int ACC  = 36;
  localparam int ACCS = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] skip_samples = '0;
  logic          phi1 = 1'b0;
  logic          phi2 = 1'b0;
  logic [AW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          pixel_ready = 1'b0;
  logic [3:0]    err_b, err_s;
  logic          sat_b, sat_s;

  skipper_cds_accum_if #(.ACC_WIDTH(ACC))  pif_b ();
  skipper_cds_accum_if #(.ACC_WIDTH(ACCS)) pif_s ();
  assign pif_b.pixel_ready = pixel_ready;
  assign pif_s.pixel_ready = pixel_ready;

  always #5 clk = ~clk;

  skipper_cds_accum #(.ACC_WIDTH(ACC)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start),
    .skip_samples(skip_samples), .phi1(phi1), .phi2(phi2),
    .adc_data(adc_data), .adc_valid(adc_valid), .pix(pif_b),
    .err_flags(err_b), .pixel_sat(sat_b)
  );

  skipper_cds_accum #(.ACC_WIDTH(ACCS)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start),
    .skip_samples(skip_samples), .phi1(phi1), .phi2(phi2),
    .adc_data(adc_data), .adc_valid(adc_valid), .pix(pif_s),
    .err_flags(err_s), .pixel_sat(sat_s)
  );

  int         n_checks = 0;
  int         n_pass = 0;
  longint     m_diffs[$];
  logic [3:0] m_err;

  // Expected pixel: exact integer sum of per-iteration diffs,
  // then clipped step by step or wrapped to w bits.
  function automatic longint model_acc(input int w, output bit sat);
`ifdef CDS_SATURATE_EN
    longint a, mx, mn;
    a = 0;
    sat = 1'b0;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    foreach (m_diffs[i]) begin
      a = a + m_diffs[i];
      if (a > mx) begin
        a = mx;
        sat = 1'b1;
      end else if (a < mn) begin
        a = mn;
        sat = 1'b1;
      end
    end
    return a;
`else
    longint a, m, r;
    a = 0;
    sat = 1'b0;
    foreach (m_diffs[i]) a = a + m_diffs[i];
    m = longint'(1) <<< w;
    r = a % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pixel(input int skip);
    skip_samples = SW'(skip);
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_diffs.delete();
    m_err = '0;
  endtask

  // One window of n cycles; val<0 means random data; ovl is the index
  // of a cycle with both phases high (sample 7, must be dropped).
  task automatic window(input bit sg, input int n, input int val,
                        input int pct, input int ovl,
                        output longint sum, output int cnt);
    sum = 0;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      phi1 = !sg;
      phi2 = sg;
      adc_data = (val < 0) ? AW'($urandom_range(65535)) : AW'(val);
      adc_valid = ($urandom_range(99) < pct);
      if (i == ovl) begin
        phi1 = 1'b1;
        phi2 = 1'b1;
        adc_data = 7;
        adc_valid = 1'b1;
        m_err[1] = 1'b1;
      end else if (adc_valid) begin
        if (cnt == 255) m_err[3] = 1'b1;
        else begin
          sum = sum + longint'(adc_data);
          cnt++;
        end
      end
      cyc();
    end
    phi1 = 1'b0;
    phi2 = 1'b0;
    adc_data = AW'($urandom);
    adc_valid = 1'b1;
    cyc();
    adc_valid = 1'b0;
  endtask

  // Ends in the update cycle of the iteration.
  task automatic run_iter(input int nb, input int vb, input int pb,
                          input int ns, input int vs, input int ps,
                          input int ovl);
    longint bs, ss;
    int bc, sc;
    window(1'b0, nb, vb, pb, ovl, bs, bc);
    window(1'b1, ns, vs, ps, -1, ss, sc);
    m_diffs.push_back(ss - bs);
    if (bc != sc) m_err[0] = 1'b1;
  endtask

  task automatic accept();
    pixel_ready = 1'b1;
    cyc();
    pixel_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0 || pif_s.pixel_valid !== 1'b0)
      $display("FAIL reset valid: got %b required 0", pif_b.pixel_valid);
    else n_pass++;
    n_checks++;
    if (pif_b.pixel_data !== '0 || pif_s.pixel_data !== '0)
      $display("FAIL reset data: got %0d required 0",
               longint'(pif_b.pixel_data));
    else n_pass++;
    n_checks++;
    if (err_b !== 4'h0 || err_s !== 4'h0)
      $display("FAIL reset err: got %h required 0", err_b);
    else n_pass++;
    n_checks++;
    if (sat_b !== 1'b0 || sat_s !== 1'b0)
      $display("FAIL reset sat: got %b required 0", sat_b);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) cyc();
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0)
      $display("FAIL reset idle valid: got %b required 0",
               pif_b.pixel_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    longint eb, es;
    bit sb, ss;
    start_pixel(0);
    run_iter(4, 100, 100, 4, 250, 100, -1);
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0)
      $display("FAIL basic early valid: got %b required 0",
               pif_b.pixel_valid);
    else n_pass++;
    cyc();
    eb = model_acc(ACC, sb);
    es = model_acc(ACCS, ss);
    n_checks++;
    if (pif_b.pixel_valid !== 1'b1)
      $display("FAIL basic latency: got %b required 1",
               pif_b.pixel_valid);
    else n_pass++;
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb)
      $display("FAIL basic data_b: got %0d required %0d",
               longint'(pif_b.pixel_data), eb);
    else n_pass++;
    n_checks++;
    if (longint'(pif_s.pixel_data) !== es)
      $display("FAIL basic data_s: got %0d required %0d",
               longint'(pif_s.pixel_data), es);
    else n_pass++;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL basic err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0)
      $display("FAIL basic release: got %b required 0",
               pif_b.pixel_valid);
    else n_pass++;
  endtask

  task automatic test_skip();
    longint eb;
    bit sb;
    start_pixel(9);
    for (int i = 0; i < 10; i++) begin
      run_iter(4, 1000, 100, 4, 1010, 100, -1);
      cyc();
      n_checks++;
      if (pif_b.pixel_valid !== (i == 9))
        $display("FAIL skip valid it%0d: got %b required %b",
                 i, pif_b.pixel_valid, (i == 9));
      else n_pass++;
    end
    eb = model_acc(ACC, sb);
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb)
      $display("FAIL skip data: got %0d required %0d",
               longint'(pif_b.pixel_data), eb);
    else n_pass++;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL skip err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
  endtask

  task automatic test_mismatch();
    longint eb;
    bit sb;
    start_pixel(0);
    run_iter(3, 500, 100, 4, 500, 100, -1);
    cyc();
    eb = model_acc(ACC, sb);
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb)
      $display("FAIL mismatch data: got %0d required %0d",
               longint'(pif_b.pixel_data), eb);
    else n_pass++;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL mismatch err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
  endtask

  task automatic test_overlap();
    longint eb;
    bit sb;
    start_pixel(0);
    run_iter(6, 300, 100, 5, 400, 100, 2);
    cyc();
    eb = model_acc(ACC, sb);
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb)
      $display("FAIL overlap data: got %0d required %0d",
               longint'(pif_b.pixel_data), eb);
    else n_pass++;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL overlap err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
  endtask

  task automatic test_random();
    longint eb, es;
    bit sb, ss;
    int skip;
    for (int p = 0; p < 8; p++) begin
      skip = int'($urandom_range(3));
      start_pixel(skip);
      for (int it = 0; it <= skip; it++) begin
        run_iter(int'($urandom_range(12, 1)), -1, 75,
                 int'($urandom_range(12, 1)), -1, 75, -1);
        cyc();
      end
      eb = model_acc(ACC, sb);
      es = model_acc(ACCS, ss);
      n_checks++;
      if (pif_b.pixel_valid !== 1'b1)
        $display("FAIL random%0d valid: got %b required 1",
                 p, pif_b.pixel_valid);
      else n_pass++;
      n_checks++;
      if (longint'(pif_b.pixel_data) !== eb)
        $display("FAIL random%0d data_b: got %0d required %0d",
                 p, longint'(pif_b.pixel_data), eb);
      else n_pass++;
      n_checks++;
      if (longint'(pif_s.pixel_data) !== es)
        $display("FAIL random%0d data_s: got %0d required %0d",
                 p, longint'(pif_s.pixel_data), es);
      else n_pass++;
      n_checks++;
      if (err_b !== m_err || err_s !== m_err)
        $display("FAIL random%0d err: got %h required %h",
                 p, err_b, m_err);
      else n_pass++;
      n_checks++;
      if (sat_s !== ss)
        $display("FAIL random%0d sat_s: got %b required %b",
                 p, sat_s, ss);
      else n_pass++;
      accept();
    end
  endtask

  task automatic test_back_to_back();
    longint eb;
    bit sb;
    start_pixel(1);
    for (int it = 0; it < 2; it++) begin
      run_iter(3, -1, 100, 3, -1, 100, -1);
      cyc();
    end
    eb = model_acc(ACC, sb);
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (pif_b.pixel_valid !== 1'b1 ||
          longint'(pif_b.pixel_data) !== eb)
        $display("FAIL hold c%0d: got %b/%0d required 1/%0d", c,
                 pif_b.pixel_valid, longint'(pif_b.pixel_data), eb);
      else n_pass++;
      start = (c == 10);
      skip_samples = SW'($urandom_range(7));
      cyc();
      start = 1'b0;
    end
    m_err[2] = 1'b1;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL overrun err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0)
      $display("FAIL overrun release: got %b required 0",
               pif_b.pixel_valid);
    else n_pass++;
    repeat (3) cyc();
    n_checks++;
    if (pif_b.pixel_valid !== 1'b0 || err_b !== m_err)
      $display("FAIL overrun idle: got %b/%h required 0/%h",
               pif_b.pixel_valid, err_b, m_err);
    else n_pass++;
  endtask

  task automatic test_win_sat();
    longint eb;
    bit sb;
    start_pixel(0);
    run_iter(256, 10, 100, 255, 10, 100, -1);
    cyc();
    eb = model_acc(ACC, sb);
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb)
      $display("FAIL winsat data: got %0d required %0d",
               longint'(pif_b.pixel_data), eb);
    else n_pass++;
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL winsat err: got %h required %h", err_b, m_err);
    else n_pass++;
    accept();
  endtask

  task automatic test_saturate();
    longint eb, es;
    bit sb, ss;
    start_pixel(3);
    for (int it = 0; it < 4; it++) begin
      run_iter(2, 0, 0, 4, 255, 100, -1);
      cyc();
    end
    eb = model_acc(ACC, sb);
    es = model_acc(ACCS, ss);
    n_checks++;
    if (longint'(pif_s.pixel_data) !== es)
      $display("FAIL sat data_s: got %0d required %0d",
               longint'(pif_s.pixel_data), es);
    else n_pass++;
    n_checks++;
    if (sat_s !== ss)
      $display("FAIL sat flag_s: got %b required %b", sat_s, ss);
    else n_pass++;
    n_checks++;
    if (longint'(pif_b.pixel_data) !== eb || sat_b !== sb)
      $display("FAIL sat data_b: got %0d/%b required %0d/%b",
               longint'(pif_b.pixel_data), sat_b, eb, sb);
    else n_pass++;
    n_checks++;
    if (err_s !== m_err)
      $display("FAIL sat err: got %h required %h", err_s, m_err);
    else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    longint bs;
    int bc;
    bit seen;
    start_pixel(1);
    run_iter(4, 100, 100, 4, 300, 100, -1);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_err[2] = 1'b1;
    window(1'b0, 3, 200, 100, -1, bs, bc);
    n_checks++;
    if (err_b !== m_err)
      $display("FAIL rstmid pre err: got %h required %h", err_b, m_err);
    else n_pass++;
    phi2 = 1'b1;
    adc_data = 55;
    adc_valid = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pif_b.pixel_data !== '0 || pif_s.pixel_data !== '0)
      $display("FAIL rstmid data: got %0d required 0",
               longint'(pif_b.pixel_data));
    else n_pass++;
    n_checks++;
    if (err_b !== 4'h0 || sat_b !== 1'b0 || pif_b.pixel_valid !== 1'b0)
      $display("FAIL rstmid flags: got %h/%b/%b required 0/0/0",
               err_b, sat_b, pif_b.pixel_valid);
    else n_pass++;
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) phi2 = 1'b0;
      cyc();
      if (pif_b.pixel_valid !== 1'b0) seen = 1'b1;
    end
    adc_valid = 1'b0;
    n_checks++;
    if (seen !== 1'b0 || err_b !== 4'h0)
      $display("FAIL rstmid after: got %b/%h required 0/0", seen, err_b);
    else n_pass++;
  endtask

  initial begin
    m_err = '0;
    #2;
    reset_n = 1'b0;
    repeat (2) cyc();
    test_reset();
    test_basic();
    test_skip();
    test_mismatch();
    test_overlap();
    test_random();
    test_back_to_back();
    test_win_sat();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
